spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI slave with CPOL/CPHA/bit-order parameters, oversampled on i_clk.
//   i_sclk/i_cs_n/i_mosi : SPI pins (async, 2-flop synchronized)
//   o_miso, o_miso_oe    : serial data out and its pad enable (high while selected)
//   i_tx_data/valid, o_tx_ready : single-entry TX holding register, ready when empty
//   o_rx_data/valid, i_rx_ready : last received word, valid until accepted
//   o_busy               : frame in progress
//   o_overrun/o_underrun : one-cycle pulses for a lost RX word / zero-filled TX word
module spi_slave #(
  parameter int DATA_W = 8,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0,
  parameter bit LSB    = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_underrun
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;

  logic [1:0]        sclk_s, cs_s, mosi_s, warm;
  logic              sclk_q, cs_q, armed;
  logic [DATA_W-1:0] hold, tx_sr, rx_sr, ld_word, rx_nxt;
  logic              hold_full, udr_pend;
  logic [CW-1:0]     cnt;

  function automatic logic head(input logic [DATA_W-1:0] x);
    return LSB ? x[0] : x[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] x);
    return LSB ? (x >> 1) : (x << 1);
  endfunction

  // Synchronizers plus one more stage for edge detection. 'armed' blocks a CS
  // fall until CS has been seen high once the chain reflects the real pin, so a
  // frame cut by reset is not resumed when reset lifts with CS still low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_s <= {2{CPOL}};
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      sclk_q <= CPOL;
      cs_q   <= 1'b1;
      warm   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], i_sclk};
      cs_s   <= {cs_s[0], i_cs_n};
      mosi_s <= {mosi_s[0], i_mosi};
      sclk_q <= sclk_s[1];
      cs_q   <= cs_s[1];
      warm   <= {warm[0], 1'b1};
      if (warm[1] && cs_s[1]) armed <= 1'b1;
    end
  end

  logic lead, trail, cs_fall, cs_rise, start, stop, smp, shf, word_end, load;
  assign lead     = (sclk_q == CPOL) && (sclk_s[1] != CPOL);
  assign trail    = (sclk_q != CPOL) && (sclk_s[1] == CPOL);
  assign cs_fall  = armed && cs_q && !cs_s[1];
  assign cs_rise  = !cs_q && cs_s[1];
  assign start    = (state == IDLE) && cs_fall;
  assign stop     = (state == ACTIVE) && cs_rise;
  assign smp      = (state == ACTIVE) && !cs_rise && (CPHA ? trail : lead);
  // CPHA=0 reloads on the last sample edge, so the trailing edge that closes
  // the word (cnt back at 0) must not shift the freshly loaded first bit away.
  assign shf      = (state == ACTIVE) && !cs_rise && (CPHA ? lead : trail) &&
                    (CPHA || (cnt != '0));
  assign word_end = smp && (cnt == CW'(DATA_W-1));
  assign load     = start || word_end;
  assign ld_word  = hold_full ? hold : '0;
  assign rx_nxt   = LSB ? {mosi_s[1], rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], mosi_s[1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cnt        <= '0;
      udr_pend   <= 1'b0;
      o_miso     <= 1'b0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
      if (start) state <= ACTIVE;
      if (stop)  state <= IDLE;

      // TX side: load holding register (or zeros) into the shifter
      if (load) begin
        hold_full <= 1'b0;
        if (CPHA) tx_sr <= ld_word;
        else begin
          o_miso <= head(ld_word);
          tx_sr  <= adv(ld_word);
        end
      end else if (shf) begin
        o_miso <= head(tx_sr);
        tx_sr  <= adv(tx_sr);
      end
      if (i_tx_valid && !hold_full) begin
        hold      <= i_tx_data;
        hold_full <= 1'b1;
      end

      // A reload at word end only matters if the master clocks another word,
      // so a zero-fill there is reported on that word's first sample edge.
      if (start && !hold_full) o_underrun <= 1'b1;
      if (word_end) udr_pend <= !hold_full;
      else if (smp && (cnt == '0) && udr_pend) begin
        o_underrun <= 1'b1;
        udr_pend   <= 1'b0;
      end

      // RX side
      if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
      if (smp) begin
        rx_sr <= rx_nxt;
        cnt   <= word_end ? '0 : cnt + 1'b1;
      end
      if (word_end) begin
        o_rx_data  <= rx_nxt;
        o_rx_valid <= 1'b1;
        if (o_rx_valid && !i_rx_ready) o_overrun <= 1'b1;
      end

      if (stop) begin
        cnt      <= '0;
        rx_sr    <= '0;
        udr_pend <= 1'b0;
        o_miso   <= 1'b0;
      end
    end
  end

  assign o_busy     = (state == ACTIVE);
  assign o_miso_oe  = (state == ACTIVE);
  assign o_tx_ready = !hold_full;

endmodule
